// File: rtl/lmem_pkg.sv
// Shared widths, memory-select codes and arbiter state encoding for the layer-memory port.
package lmem_pkg;

  localparam int LMEM_ADDR_W = 12;
  localparam int LMEM_DATA_W = 20;
  localparam int LMEM_SEL_W  = 3;

  localparam logic [LMEM_SEL_W-1:0] SEL_L0_K0 = 3'd1;
  localparam logic [LMEM_SEL_W-1:0] SEL_L0_K1 = 3'd2;
  localparam logic [LMEM_SEL_W-1:0] SEL_L1_K0 = 3'd3;
  localparam logic [LMEM_SEL_W-1:0] SEL_L1_K1 = 3'd4;
  localparam logic [LMEM_SEL_W-1:0] SEL_L2    = 3'd5;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } lmem_state_e;

  // Codes 0, 6 and 7 address no memory bank.
  function automatic logic sel_is_valid(input logic [LMEM_SEL_W-1:0] sel);
    return (sel >= SEL_L0_K0) && (sel <= SEL_L2);
  endfunction

endpackage

// File: rtl/lmem_rr_pick.sv
// Round-robin picker: first set bit of req_mask searching upward from ptr+1, wrapping.
module lmem_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req_mask[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/lmem_port_arbiter.sv
// Round-robin arbiter sharing the single layer-memory port among N_REQ requesters.
// Define LMEM_ARB_WR_PRIO_EN to make pending writes win over pending reads.
module lmem_port_arbiter
  import lmem_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_wr,
  input  logic [LMEM_SEL_W*N_REQ-1:0]   req_sel,
  input  logic [LMEM_ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [LMEM_DATA_W*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [LMEM_DATA_W-1:0]        rsp_data,
  output logic                          cwr,
  output logic [LMEM_ADDR_W-1:0]        caddr_wr,
  output logic [LMEM_DATA_W-1:0]        cdata_wr,
  output logic                          crd,
  output logic [LMEM_ADDR_W-1:0]        caddr_rd,
  input  logic [LMEM_DATA_W-1:0]        cdata_rd,
  output logic [LMEM_SEL_W-1:0]         csel,
  output logic                          busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 2;

  lmem_state_e      state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] owner_p1;
  logic             rd_ok_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

`ifdef LMEM_ARB_WR_PRIO_EN
  logic [N_REQ-1:0] wr_gnt, rd_gnt;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_any, rd_any;

  lmem_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_wr (
    .req_mask (req_valid & req_wr),
    .ptr      (ptr),
    .gnt      (wr_gnt),
    .idx      (wr_idx),
    .any      (wr_any)
  );

  lmem_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_rd (
    .req_mask (req_valid & ~req_wr),
    .ptr      (ptr),
    .gnt      (rd_gnt),
    .idx      (rd_idx),
    .any      (rd_any)
  );

  // Both classes share one pointer so fairness carries across write/read bursts.
  assign pick_gnt = wr_any ? wr_gnt : rd_gnt;
  assign pick_idx = wr_any ? wr_idx : rd_idx;
  assign pick_any = wr_any | rd_any;
`else
  lmem_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_mask (req_valid),
    .ptr      (ptr),
    .gnt      (pick_gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );
`endif

  logic                   grant_en;
  logic                   g_wr;
  logic [LMEM_SEL_W-1:0]  g_sel;
  logic [LMEM_ADDR_W-1:0] g_addr;
  logic [LMEM_DATA_W-1:0] g_data;

  assign grant_en  = !reset && (state == ARB) && pick_any;
  assign req_ready = grant_en ? pick_gnt : '0;
  assign busy      = !reset && ((|req_valid) || (state != ARB));

  assign g_wr   = req_wr[pick_idx];
  assign g_sel  = req_sel[pick_idx*LMEM_SEL_W +: LMEM_SEL_W];
  assign g_addr = req_addr[pick_idx*LMEM_ADDR_W +: LMEM_ADDR_W];
  assign g_data = req_wdata[pick_idx*LMEM_DATA_W +: LMEM_DATA_W];

  // Grant cycle -> registered memory pins one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      ptr       <= IDX_W'(N_REQ - 1);
      owner_p1  <= '0;
      rd_ok_p1  <= 1'b0;
      cnt_p1    <= '0;
      cwr       <= 1'b0;
      crd       <= 1'b0;
      caddr_wr  <= '0;
      cdata_wr  <= '0;
      caddr_rd  <= '0;
      csel      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      cwr       <= 1'b0;
      crd       <= 1'b0;
      rsp_valid <= '0;
      unique case (state)
        ARB: begin
          if (grant_en) begin
            ptr <= pick_idx;
            if (g_wr) begin
              if (sel_is_valid(g_sel)) begin
                cwr      <= 1'b1;
                caddr_wr <= g_addr;
                cdata_wr <= g_data;
                csel     <= g_sel;
              end
            end else begin
              state    <= RD_WAIT;
              owner_p1 <= pick_idx;
              rd_ok_p1 <= sel_is_valid(g_sel);
              // RD_WAIT spans RD_LAT cycles; RD_RESP is the cycle cdata_rd is valid.
              cnt_p1   <= CNT_W'(RD_LAT - 1);
              if (sel_is_valid(g_sel)) begin
                crd      <= 1'b1;
                caddr_rd <= g_addr;
                csel     <= g_sel;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt_p1 == '0) state <= RD_RESP;
          else              cnt_p1 <= cnt_p1 - 1'b1;
        end
        RD_RESP: begin
          state     <= ARB;
          rsp_valid <= N_REQ'(1) << owner_p1;
          rsp_data  <= rd_ok_p1 ? cdata_rd : '0;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// Directed bench for lmem_port_arbiter with N_REQ=3, RD_LAT=1 and a one-cycle memory model.
module tb_lmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_wr;
  logic [8:0]  req_sel;
  logic [35:0] req_addr;
  logic [59:0] req_wdata;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [19:0] rsp_data;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic        busy;

  logic [19:0] rd_return;
  int          tests;
  int          fails;

  lmem_port_arbiter #(.N_REQ(3), .RD_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_sel   (req_sel),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .cwr       (cwr),
    .caddr_wr  (caddr_wr),
    .cdata_wr  (cdata_wr),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .csel      (csel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data one cycle after crd; anything else is a poison pattern.
  always @(posedge clk) cdata_rd <= crd ? rd_return : 20'hFFFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [2:0] sel,
                         input logic [11:0] addr, input logic [19:0] data);
    req_wr[i]            = wr;
    req_sel[i*3 +: 3]    = sel;
    req_addr[i*12 +: 12] = addr;
    req_wdata[i*20 +: 20] = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    rd_return = 20'h0;
    req_valid = 3'b111;
    req_wr    = '0;
    req_sel   = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 3'd1, 12'(10 + i), 20'(16'hA000 + i));

    // Reset held with all requesters valid
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk("rst_cwr", 32'(cwr), 32'd0);
      chk("rst_crd", 32'(crd), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end

    // Release: req0 first, then continuous round-robin writes
    step();
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'b001);
    chk("first_cwr", 32'(cwr), 32'd0);
    chk("busy_pending", 32'(busy), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      #1;
      chk("rr_grant", 32'(req_ready), 32'(3'b001 << (k % 3)));
      chk("rr_cwr", 32'(cwr), 32'd1);
      chk("rr_addr", 32'(caddr_wr), 32'(10 + ((k - 1) % 3)));
    end
    step();
    req_valid = 3'b000;
    #1;
    chk("rr_last_cwr", 32'(cwr), 32'd1);
    chk("rr_last_addr", 32'(caddr_wr), 32'd11);
    chk("idle_ready", 32'(req_ready), 32'd0);

    // Single write from req1
    step();
    set_req(1, 1'b1, 3'd1, 12'd5, 20'h12345);
    req_valid = 3'b010;
    #1;
    chk("wr_ready", 32'(req_ready), 32'b010);
    chk("wr_pre_cwr", 32'(cwr), 32'd0);
    step();
    req_valid = 3'b000;
    #1;
    chk("wr_cwr", 32'(cwr), 32'd1);
    chk("wr_addr", 32'(caddr_wr), 32'd5);
    chk("wr_data", 32'(cdata_wr), 32'h12345);
    chk("wr_csel", 32'(csel), 32'd1);
    step();
    set_req(2, 1'b0, 3'd3, 12'd40, 20'h0);
    set_req(0, 1'b1, 3'd2, 12'd7, 20'h55555);
    req_valid = 3'b101;
    rd_return = 20'h0ABCD;
    #1;
    chk("wr_cwr_drop", 32'(cwr), 32'd0);
    chk("wr_addr_hold", 32'(caddr_wr), 32'd5);

    // Read from req2 while req0 write waits
    chk("rd_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = 3'b001;
    #1;
    chk("rd_crd", 32'(crd), 32'd1);
    chk("rd_addr", 32'(caddr_rd), 32'd40);
    chk("rd_csel", 32'(csel), 32'd3);
    chk("rd_t1_ready", 32'(req_ready), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    step();
    #1;
    chk("rd_t2_ready", 32'(req_ready), 32'd0);
    chk("rd_t2_rsp", 32'(rsp_valid), 32'd0);
    chk("rd_t2_crd", 32'(crd), 32'd0);
    step();
    #1;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'b100);
    chk("rd_rsp_data", 32'(rsp_data), 32'h0ABCD);
    chk("rd_t3_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = 3'b000;
    #1;
    chk("rd_after_cwr", 32'(cwr), 32'd1);
    chk("rd_after_csel", 32'(csel), 32'd2);
    chk("rd_after_data", 32'(cdata_wr), 32'h55555);
    chk("rd_after_rsp", 32'(rsp_valid), 32'd0);

    // Invalid-select write is accepted and dropped
    step();
    set_req(1, 1'b1, 3'd0, 12'd9, 20'h99999);
    req_valid = 3'b010;
    #1;
    chk("inv_wr_ready", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b000;
    #1;
    chk("inv_wr_cwr", 32'(cwr), 32'd0);
    chk("inv_wr_addr", 32'(caddr_wr), 32'd7);

    // Invalid-select read keeps read timing and returns zero
    step();
    set_req(2, 1'b0, 3'd7, 12'd11, 20'h0);
    rd_return = 20'h11111;
    req_valid = 3'b100;
    #1;
    chk("inv_rd_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = 3'b000;
    #1;
    chk("inv_rd_crd", 32'(crd), 32'd0);
    chk("inv_rd_addr", 32'(caddr_rd), 32'd40);
    chk("inv_rd_busy", 32'(busy), 32'd1);
    step();
    #1;
    chk("inv_rd_t2_rsp", 32'(rsp_valid), 32'd0);
    step();
    #1;
    chk("inv_rd_rsp_valid", 32'(rsp_valid), 32'b100);
    chk("inv_rd_rsp_data", 32'(rsp_data), 32'd0);
    step();
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a read
    step();
    set_req(0, 1'b0, 3'd1, 12'd3, 20'h0);
    rd_return = 20'h22222;
    req_valid = 3'b001;
    #1;
    chk("mid_rd_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = 3'b000;
    #1;
    chk("mid_rd_crd", 32'(crd), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy_after", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      step();
      #1;
    end

    // Read and write contend on the same cycle; pointer favours req0
    set_req(0, 1'b0, 3'd1, 12'd3, 20'h0);
    set_req(1, 1'b1, 3'd1, 12'd20, 20'h00001);
    req_valid = 3'b011;
    #1;
`ifdef LMEM_ARB_WR_PRIO_EN
    chk("prio_grant", 32'(req_ready), 32'b010);
`else
    chk("prio_grant", 32'(req_ready), 32'b001);
`endif
    step();
    req_valid = 3'b000;
    #1;
`ifdef LMEM_ARB_WR_PRIO_EN
    chk("prio_cwr", 32'(cwr), 32'd1);
`else
    chk("prio_crd", 32'(crd), 32'd1);
`endif
    for (int c = 0; c < 3; c++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
